// File: rtl/multi_queue_ctrlr.sv
// multi_queue_ctrlr: per-channel big-endian word assembly from tagged bytes,
// per-channel word FIFOs with sticky drop detection, and a round-robin
// drain into a registered valid/ready output stage.
module multi_queue_ctrlr #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CH_W       = 1,
  parameter int unsigned BYTE_W     = 8,
  parameter int unsigned WORD_BYTES = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                           clk_div_8,
  input  logic                           reset,
  input  logic [BYTE_W-1:0]              par_out,
  input  logic                           par_valid,
  input  logic [CH_W-1:0]                decode_ch,
  input  logic                           data_ready,
  output logic [BYTE_W*WORD_BYTES-1:0]   data_out,
  output logic [CH_W-1:0]                data_ch,
  output logic                           valid_data_out,
  output logic [NUM_CH-1:0]              fifo_full,
  output logic [NUM_CH-1:0]              drop_flag
);

  localparam int unsigned WORD_W = BYTE_W * WORD_BYTES;
  localparam int unsigned CNT_W  = $clog2(WORD_BYTES);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(WORD_BYTES - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(DEPTH);

  // Assembly state
  logic [CNT_W-1:0]  bcnt_q [NUM_CH];
  logic [CNT_W-1:0]  bcnt_d [NUM_CH];
  logic [WORD_W-1:0] hold_q [NUM_CH];
  logic [WORD_W-1:0] hold_d [NUM_CH];

  // FIFO state
  logic [WORD_W-1:0] mem_q  [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_q   [NUM_CH];
  logic [PTR_W-1:0]  wr_d   [NUM_CH];
  logic [PTR_W-1:0]  rd_q   [NUM_CH];
  logic [PTR_W-1:0]  rd_d   [NUM_CH];
  logic [FCNT_W-1:0] fcnt_q [NUM_CH];
  logic [FCNT_W-1:0] fcnt_d [NUM_CH];
  logic [NUM_CH-1:0] full_q, full_d;
  logic [NUM_CH-1:0] drop_q, drop_d;
  logic [NUM_CH-1:0] push, pop;

  // Output stage and arbiter
  logic [WORD_W-1:0] data_q, data_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              valid_q, valid_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic              pick_valid;
  logic [CH_W-1:0]   pick_ch;
  logic [CH_W-1:0]   arb_idx;
  logic              load;
  logic              byte_acc;

  assign byte_acc = par_valid && (32'(decode_ch) < NUM_CH);

  // Round-robin search for the first non-empty FIFO starting at rr_q
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = '0;
    arb_idx    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      arb_idx = CH_W'((32'(rr_q) + i) % NUM_CH);
      if (!pick_valid && (fcnt_q[arb_idx] != '0)) begin
        pick_valid = 1'b1;
        pick_ch    = arb_idx;
      end
    end
  end

  assign load = pick_valid && (!valid_q || data_ready);

  // Pop strobe for the arbitrated channel
  always_comb begin
    pop = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      pop[c] = load && (pick_ch == CH_W'(c));
    end
  end

  // Per-channel byte assembly, FIFO push/drop decision and pointer/count update.
  // A full FIFO still accepts a completed word when the arbiter pops it on the
  // same edge, so the drop test looks at the pop strobe as well as the count.
  always_comb begin
    push = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      bcnt_d[c] = bcnt_q[c];
      hold_d[c] = hold_q[c];
      wr_d[c]   = wr_q[c];
      rd_d[c]   = rd_q[c];
      fcnt_d[c] = fcnt_q[c];
      drop_d[c] = drop_q[c];
      full_d[c] = full_q[c];
      if (byte_acc && (decode_ch == CH_W'(c))) begin
        hold_d[c] = {hold_q[c][WORD_W-BYTE_W-1:0], par_out};
        if (bcnt_q[c] == LAST_BYTE) begin
          bcnt_d[c] = '0;
          if ((fcnt_q[c] != FULL_CNT) || pop[c]) begin
            push[c] = 1'b1;
          end else begin
            drop_d[c] = 1'b1;
          end
        end else begin
          bcnt_d[c] = bcnt_q[c] + 1'b1;
        end
      end
      if (push[c]) begin
        wr_d[c] = wr_q[c] + 1'b1;
      end
      if (pop[c]) begin
        rd_d[c] = rd_q[c] + 1'b1;
      end
      case ({push[c], pop[c]})
        2'b10:   fcnt_d[c] = fcnt_q[c] + 1'b1;
        2'b01:   fcnt_d[c] = fcnt_q[c] - 1'b1;
        default: fcnt_d[c] = fcnt_q[c];
      endcase
      full_d[c] = (fcnt_d[c] == FULL_CNT);
    end
  end

  // Output register next state: load on free/accepted slot, else drop valid once taken
  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    rr_d    = rr_q;
    if (load) begin
      data_d  = mem_q[pick_ch][rd_q[pick_ch]];
      ch_d    = pick_ch;
      valid_d = 1'b1;
      rr_d    = (32'(pick_ch) == NUM_CH - 1) ? '0 : pick_ch + 1'b1;
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_div_8) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        bcnt_q[c] <= '0;
        hold_q[c] <= '0;
        wr_q[c]   <= '0;
        rd_q[c]   <= '0;
        fcnt_q[c] <= '0;
      end
      full_q  <= '0;
      drop_q  <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      rr_q    <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        bcnt_q[c] <= bcnt_d[c];
        hold_q[c] <= hold_d[c];
        wr_q[c]   <= wr_d[c];
        rd_q[c]   <= rd_d[c];
        fcnt_q[c] <= fcnt_d[c];
      end
      full_q  <= full_d;
      drop_q  <= drop_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
    end
  end

  // FIFO storage write; contents need no reset since pointers/counts gate reads
  always_ff @(posedge clk_div_8) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        mem_q[c][wr_q[c]] <= hold_d[c];
      end
    end
  end

  assign data_out       = data_q;
  assign data_ch        = ch_q;
  assign valid_data_out = valid_q;
  assign fifo_full      = full_q;
  assign drop_flag      = drop_q;

endmodule

// File: tb/tb_multi_queue_ctrlr.sv
// Bench for multi_queue_ctrlr: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based behavioural model.
module tb_multi_queue_ctrlr;

  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;
  localparam int BYTE_W = 8;
  localparam int WB     = 8;
  localparam int DEPTH  = 4;
  localparam int W      = BYTE_W * WB;

  logic              clk = 1'b0;
  logic              reset;
  logic [BYTE_W-1:0] par_out;
  logic              par_valid;
  logic [CH_W-1:0]   decode_ch;
  logic              data_ready;
  logic [W-1:0]      data_out;
  logic [CH_W-1:0]   data_ch;
  logic              valid_data_out;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] drop_flag;

  multi_queue_ctrlr #(
    .NUM_CH    (NUM_CH),
    .CH_W      (CH_W),
    .BYTE_W    (BYTE_W),
    .WORD_BYTES(WB),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_div_8     (clk),
    .reset         (reset),
    .par_out       (par_out),
    .par_valid     (par_valid),
    .decode_ch     (decode_ch),
    .data_ready    (data_ready),
    .data_out      (data_out),
    .data_ch       (data_ch),
    .valid_data_out(valid_data_out),
    .fifo_full     (fifo_full),
    .drop_flag     (drop_flag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural model: byte lists, word queues, output register, rr pointer
  logic [7:0]        mp [NUM_CH][$];
  logic [W-1:0]      mq [NUM_CH][$];
  logic              m_valid;
  logic [W-1:0]      m_data;
  int                m_ch;
  int                m_rr;
  logic [NUM_CH-1:0] m_drop;
  logic [NUM_CH-1:0] m_full;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge(input logic rst, input logic pv, input int ch,
                            input logic [7:0] b, input logic rdy);
    logic [W-1:0] w;
    int  c;
    bit  found;
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        mp[k].delete();
        mq[k].delete();
      end
      m_valid = 1'b0; m_data = '0; m_ch = 0; m_rr = 0; m_drop = '0; m_full = '0;
    end else begin
      found = 1'b0;
      if (!m_valid || rdy) begin
        for (int k = 0; k < NUM_CH; k++) begin
          c = (m_rr + k) % NUM_CH;
          if (!found && mq[c].size() > 0) begin
            found   = 1'b1;
            m_data  = mq[c].pop_front();
            m_ch    = c;
            m_valid = 1'b1;
            m_rr    = (c + 1) % NUM_CH;
          end
        end
      end
      if (!found && m_valid && rdy) m_valid = 1'b0;
      if (pv && ch < NUM_CH) begin
        mp[ch].push_back(b);
        if (mp[ch].size() == WB) begin
          w = '0;
          for (int k = 0; k < WB; k++) w = (w << BYTE_W) | W'(mp[ch][k]);
          mp[ch].delete();
          if (mq[ch].size() == DEPTH) m_drop[ch] = 1'b1;
          else mq[ch].push_back(w);
        end
      end
      for (int k = 0; k < NUM_CH; k++) m_full[k] = (mq[k].size() == DEPTH);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later
  task automatic step(input logic rst, input logic pv, input int ch,
                      input logic [7:0] b, input logic rdy);
    reset      = rst;
    par_valid  = pv;
    decode_ch  = CH_W'(ch);
    par_out    = b;
    data_ready = rdy;
    @(posedge clk);
    model_edge(rst, pv, ch, b, rdy);
    #1;
    cyc++;
    chk("valid", 64'(valid_data_out), 64'(m_valid));
    chk("data",  64'(data_out),       64'(m_data));
    chk("ch",    64'(data_ch),        64'(m_ch));
    chk("full",  64'(fifo_full),      64'(m_full));
    chk("drop",  64'(drop_flag),      64'(m_drop));
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 0, 8'h00, rdy);
  endtask

  task automatic send_word(input int ch, input logic [7:0] base, input logic rdy);
    for (int i = 0; i < WB; i++) step(1'b0, 1'b1, ch, base + 8'(i), rdy);
  endtask

  int hs;
  int seq[$];
  logic rbias;

  initial begin
    // Reset state
    step(1'b1, 1'b0, 0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 0, 8'h00, 1'b0);
    chk("rst_valid", 64'(valid_data_out), 64'd0);
    chk("rst_data",  64'(data_out),       64'd0);

    // Single word latency and hold time
    send_word(0, 8'h01, 1'b1);
    chk("lat_n", 64'(valid_data_out), 64'd0);
    idle(1'b1);
    chk("lat_n1_valid", 64'(valid_data_out), 64'd1);
    chk("lat_n1_data",  64'(data_out),       64'h0102030405060708);
    chk("lat_n1_ch",    64'(data_ch),        64'd0);
    idle(1'b1);
    chk("hold1_valid",  64'(valid_data_out), 64'd0);
    chk("hold1_data",   64'(data_out),       64'h0102030405060708);

    // Interleaved channels
    for (int i = 0; i < WB; i++) begin
      step(1'b0, 1'b1, 0, 8'hA0 + 8'(i), 1'b1);
      step(1'b0, 1'b1, 1, 8'hB0 + 8'(i), 1'b1);
    end
    chk("ilv_a_data", 64'(data_out), 64'hA0A1A2A3A4A5A6A7);
    chk("ilv_a_ch",   64'(data_ch),  64'd0);
    idle(1'b1);
    chk("ilv_b_data", 64'(data_out), 64'hB0B1B2B3B4B5B6B7);
    chk("ilv_b_ch",   64'(data_ch),  64'd1);
    repeat (3) idle(1'b1);

    // Backpressure and overflow on ch1
    for (int k = 0; k < 6; k++) send_word(1, 8'(8'h10 * k), 1'b0);
    chk("ovf_full1", 64'(fifo_full[1]), 64'd1);
    chk("ovf_drop1", 64'(drop_flag[1]), 64'd1);
    hs = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid_data_out) hs++;
      idle(1'b1);
    end
    chk("ovf_drain_cnt", 64'(hs), 64'd5);
    chk("ovf_drop_sticky", 64'(drop_flag[1]), 64'd1);

    // Round-robin fairness
    step(1'b1, 1'b0, 0, 8'h00, 1'b0);
    send_word(0, 8'h40, 1'b0);
    send_word(0, 8'h48, 1'b0);
    send_word(1, 8'h50, 1'b0);
    send_word(1, 8'h58, 1'b0);
    seq.delete();
    for (int i = 0; i < 8; i++) begin
      if (valid_data_out) seq.push_back(int'(data_ch));
      idle(1'b1);
    end
    chk("rr_len", 64'(seq.size()), 64'd4);
    if (seq.size() == 4) begin
      chk("rr_0", 64'(seq[0]), 64'd0);
      chk("rr_1", 64'(seq[1]), 64'd1);
      chk("rr_2", 64'(seq[2]), 64'd0);
      chk("rr_3", 64'(seq[3]), 64'd1);
    end

    // Invalid channel bytes leave assembly untouched
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0, 8'h11 + 8'(i), 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 3, 8'hEE, 1'b1);
    chk("inv_noout", 64'(valid_data_out), 64'd0);
    for (int i = 4; i < 8; i++) step(1'b0, 1'b1, 0, 8'h11 + 8'(i), 1'b1);
    idle(1'b1);
    chk("inv_data", 64'(data_out), 64'h1112131415161718);

    // Reset mid-word discards partial bytes
    repeat (2) idle(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0, 8'h21 + 8'(i), 1'b1);
    step(1'b1, 1'b0, 0, 8'h00, 1'b1);
    send_word(0, 8'h31, 1'b1);
    idle(1'b1);
    chk("rstmid_data", 64'(data_out), 64'h3132333435363738);

    // Full FIFO with pop and push on the same edge
    step(1'b1, 1'b0, 0, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) send_word(0, 8'(8'h60 + 8'h08 * k), 1'b0);
    chk("pp_full_pre", 64'(fifo_full[0]), 64'd1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 0, 8'h90 + 8'(i), 1'b0);
    step(1'b0, 1'b1, 0, 8'h97, 1'b1);
    chk("pp_full_post", 64'(fifo_full[0]), 64'd1);
    chk("pp_nodrop",    64'(drop_flag[0]), 64'd0);
    repeat (8) idle(1'b1);

    // Randomized traffic
    rbias = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) rbias = ~rbias;
      step(($urandom % 900) == 0,
           ($urandom % 4) != 0,
           int'($urandom_range(0, 3)),
           8'($urandom),
           rbias ? (($urandom % 5) != 0) : (($urandom % 6) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
